// File: rtl/enc8to3_evt_pkg.sv
// Shared types and helpers for the event-capturing 8-to-3 encoder family.
package enc_evt_pkg;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Returns the WIDTH-bit one-hot vector with only bit idx set.
  function automatic logic [WIDTH-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/enc8to3_evt_prio_sel8.sv
// Combinational 8-way selector: highest set bit, or first set bit at or
// above a start index with wrap-around when round-robin is requested.
module prio_sel8
  import enc_evt_pkg::*;
(
  input  logic [WIDTH-1:0] mask,
  input  logic [IDX_W-1:0] start,
  input  logic             rr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;
  logic             found;

  // Walk the candidates in priority order (downward from the top bit for
  // fixed priority, upward from start for round-robin) and keep the first hit.
  always_comb begin
    idx   = '0;
    pos   = '0;
    found = 1'b0;
    any   = |mask;
    for (int k = 0; k < WIDTH; k++) begin
      if (rr) begin
        pos = start + IDX_W'(k);
      end else begin
        pos = IDX_W'(WIDTH - 1 - k);
      end
      if (!found && mask[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc8to3_evt.sv
// Event-capturing 8-to-3 encoder: latches rising edges on the request lines
// as pending events and hands them out one index at a time over valid/ready.
module enc8to3_evt #(
  parameter int WIDTH   = 8,
  parameter int IDX_W   = 3,
  parameter int RR_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [IDX_W-1:0] out,
  output logic             valid,
  input  logic             ready,
  output logic             drop,
  output logic             busy
);

  import enc_evt_pkg::*;

  localparam logic RR = (RR_MODE != 0);

  logic [WIDTH-1:0] in_d;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] clr;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             load;
  state_t           state;

  // Selection only ever looks at registered pending bits, never at this
  // cycle's fresh edges.
  prio_sel8 u_sel (
    .mask  (pend),
    .start (rr_ptr),
    .rr    (RR),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign evt  = in & ~in_d & {WIDTH{en}};
  assign load = sel_any & ((state == ST_EMPTY) | ready);
  assign clr  = load ? onehot(sel_idx) : '0;
  assign busy = valid | (|pend);

  // Edge history, pending set and drop flag; a new edge on the bit being
  // loaded this cycle wins over its clear so the event is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_d <= '0;
      pend <= '0;
      drop <= 1'b0;
    end else begin
      in_d <= in;
      pend <= (pend & ~clr) | evt;
      drop <= |(evt & pend & ~clr);
    end
  end

  // Presentation FSM: loads the next selection on entry and on every
  // accepted handshake, so a steady ready gives one event per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      out    <= '0;
      valid  <= 1'b0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (load) begin
            out    <= sel_idx;
            valid  <= 1'b1;
            rr_ptr <= sel_idx + IDX_W'(1);
            state  <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (ready) begin
            if (load) begin
              out    <= sel_idx;
              rr_ptr <= sel_idx + IDX_W'(1);
            end else begin
              valid <= 1'b0;
              state <= ST_EMPTY;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc8to3_evt.sv
// Directed bench for enc8to3_evt: a fixed-priority and a round-robin
// instance share stimulus; expected values are hand-computed.
module tb_enc8to3_evt;

  logic       clk;
  logic       rst_n;
  logic       en_s;
  logic [7:0] in_s;
  logic       ready_s;

  logic [2:0] out_fp, out_rr;
  logic       valid_fp, valid_rr;
  logic       drop_fp, drop_rr;
  logic       busy_fp, busy_rr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] in;
    logic       en;
    logic       ready;
    logic [2:0] out_fp;
    logic [2:0] out_rr;
    logic       valid;
    logic       drop;
    logic       busy;
  } vec_t;

  vec_t vecs [12];

  enc8to3_evt #(.RR_MODE(0)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_s),
    .in    (in_s),
    .out   (out_fp),
    .valid (valid_fp),
    .ready (ready_s),
    .drop  (drop_fp),
    .busy  (busy_fp)
  );

  enc8to3_evt #(.RR_MODE(1)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_s),
    .in    (in_s),
    .out   (out_rr),
    .valid (valid_rr),
    .ready (ready_s),
    .drop  (drop_rr),
    .busy  (busy_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then step to just after the next rising edge.
  task automatic applyStimulus(input logic [7:0] i_in, input logic i_en, input logic i_ready);
    in_s    = i_in;
    en_s    = i_en;
    ready_s = i_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkFp(input string tag, input logic [2:0] e_out, input logic e_valid,
                         input logic e_drop, input logic e_busy);
    checkOutput({tag, "_fp_out"},   {5'b0, out_fp},   {5'b0, e_out});
    checkOutput({tag, "_fp_valid"}, {7'b0, valid_fp}, {7'b0, e_valid});
    checkOutput({tag, "_fp_drop"},  {7'b0, drop_fp},  {7'b0, e_drop});
    checkOutput({tag, "_fp_busy"},  {7'b0, busy_fp},  {7'b0, e_busy});
  endtask

  task automatic checkRr(input string tag, input logic [2:0] e_out, input logic e_valid,
                         input logic e_busy);
    checkOutput({tag, "_rr_out"},   {5'b0, out_rr},   {5'b0, e_out});
    checkOutput({tag, "_rr_valid"}, {7'b0, valid_rr}, {7'b0, e_valid});
    checkOutput({tag, "_rr_busy"},  {7'b0, busy_rr},  {7'b0, e_busy});
  endtask

  initial begin
    // Single-edge latency, then fixed-priority vs round-robin on 8'h25.
    //            in     en    rdy   out_fp out_rr valid drop  busy
    vecs[0]  = '{8'h10, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{8'h10, 1'b1, 1'b0, 3'd4, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{8'h10, 1'b1, 1'b0, 3'd4, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{8'h10, 1'b1, 1'b1, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h10, 1'b1, 1'b0, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h00, 1'b1, 1'b1, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'h25, 1'b1, 1'b1, 3'd4, 3'd4, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'h25, 1'b1, 1'b1, 3'd5, 3'd5, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{8'h25, 1'b1, 1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{8'h25, 1'b1, 1'b1, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{8'h25, 1'b1, 1'b1, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'h00, 1'b1, 1'b1, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0};

    rst_n   = 1'b0;
    in_s    = 8'h00;
    en_s    = 1'b0;
    ready_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkFp("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    checkRr("reset", 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].in, vecs[i].en, vecs[i].ready);
      checkFp($sformatf("vec%0d", i), vecs[i].out_fp, vecs[i].valid, vecs[i].drop, vecs[i].busy);
      checkRr($sformatf("vec%0d", i), vecs[i].out_rr, vecs[i].valid, vecs[i].busy);
    end

    // Round-robin: grant 5, then 7 and 1 pending -> 7 then 1.
    applyStimulus(8'h20, 1'b1, 1'b0); checkRr("rr0", 3'd2, 1'b0, 1'b1);
    applyStimulus(8'h20, 1'b1, 1'b0); checkRr("rr1", 3'd5, 1'b1, 1'b1);
    applyStimulus(8'hA2, 1'b1, 1'b0); checkRr("rr2", 3'd5, 1'b1, 1'b1);
    applyStimulus(8'hA2, 1'b1, 1'b1); checkRr("rr3", 3'd7, 1'b1, 1'b1);
    applyStimulus(8'hA2, 1'b1, 1'b1); checkRr("rr4", 3'd1, 1'b1, 1'b1);
    applyStimulus(8'hA2, 1'b1, 1'b1); checkRr("rr5", 3'd1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);

    // Drop/merge: bit 3 re-triggers while pending behind index 6.
    applyStimulus(8'h40, 1'b1, 1'b0); checkFp("drop0", 3'd1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h48, 1'b1, 1'b0); checkFp("drop1", 3'd6, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h40, 1'b1, 1'b0); checkFp("drop2", 3'd6, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h48, 1'b1, 1'b0); checkFp("drop3", 3'd6, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'h48, 1'b1, 1'b0); checkFp("drop4", 3'd6, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h48, 1'b1, 1'b1); checkFp("drop5", 3'd3, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h48, 1'b1, 1'b1); checkFp("drop6", 3'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h48, 1'b1, 1'b1); checkFp("drop7", 3'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);

    // Enable gating: edges under en=0 are lost, a held line is not an edge.
    applyStimulus(8'hFF, 1'b0, 1'b0); checkFp("en0", 3'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b0); checkFp("en1", 3'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0); checkFp("en2", 3'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0); checkFp("en3", 3'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);

    // Set wins: bit 2 re-arrives on the cycle it is loaded.
    applyStimulus(8'h80, 1'b1, 1'b0); checkFp("setw0", 3'd3, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h84, 1'b1, 1'b0); checkFp("setw1", 3'd7, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h80, 1'b1, 1'b0); checkFp("setw2", 3'd7, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h84, 1'b1, 1'b1); checkFp("setw3", 3'd2, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h84, 1'b1, 1'b1); checkFp("setw4", 3'd2, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h84, 1'b1, 1'b1); checkFp("setw5", 3'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);

    // Asynchronous reset in the middle of SHOW.
    applyStimulus(8'h40, 1'b1, 1'b0); checkFp("mid0", 3'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h40, 1'b1, 1'b0); checkFp("mid1", 3'd6, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkFp("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    checkRr("async_rst", 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // A line still high after release counts as a fresh edge.
    applyStimulus(8'h40, 1'b1, 1'b0);
    checkFp("post0", 3'd0, 1'b0, 1'b0, 1'b1);
    checkRr("post0", 3'd0, 1'b0, 1'b1);
    applyStimulus(8'h40, 1'b1, 1'b0);
    checkFp("post1", 3'd6, 1'b1, 1'b0, 1'b1);
    checkRr("post1", 3'd6, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc8to3_evt.md
Name: enc8to3_evt

Overview:
- Event-capturing 8-to-3 encoder, the inverse of the team's 3-to-8 decoder.
- Detects rising edges on 8 request lines and latches them as pending events.
- Presents the index of one pending event at a time on a 3-bit output with a valid/ready handshake.
- Sits between raw strobe/button/interrupt lines and a consumer that drives a dec3to8-style select.

Parameters:
- WIDTH, 8, number of request lines. Only 8 is supported; the parameter exists for package consistency.
- IDX_W, 3, index width, equal to clog2(WIDTH).
- RR_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin starting after the last granted index.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  capture enable. When 0, new edges are ignored.
- in  input  8  request lines, synchronous to clk, level signals.
- out  output  3  encoded index of the presented event.
- valid  output  1  out holds a presented event.
- ready  input  1  consumer accepts the event when valid=1 and ready=1 in the same cycle.
- drop  output  1  one-cycle pulse: an edge arrived on a bit that was already pending.
- busy  output  1  valid OR any pending bit set.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out=3'd0, valid=0, drop=0, busy=0.
  - pend=8'd0, in_d=8'd0, rr_ptr=3'd0.
- Edge detect:
  - in_d <= in every cycle, regardless of en.
  - evt = in & ~in_d & {8{en}}.
- Pending register update each cycle: pend <= (pend & ~clr) | evt.
  - clr is the one-hot of the index loaded into out this cycle, otherwise 0.
  - If evt and clr hit the same bit in one cycle, set wins: the new event stays pending.
- drop: registered, drop <= |(evt & pend & ~clr). Asserted for exactly one cycle per offending cycle. The event is merged, not queued.
- Selection from the registered pend only; evt is never selected combinationally.
  - RR_MODE=0: highest set bit of pend.
  - RR_MODE=1: first set bit searching upward from rr_ptr, wrapping 7->0.
  - rr_ptr <= granted index + 1 (mod 8) on every load.
- State machine:
  - EMPTY (valid=0): if pend != 0, load out = selected index, set valid=1, clear that bit, go to SHOW. Otherwise stay in EMPTY.
  - SHOW (valid=1): hold out stable while ready=0.
  - On valid&&ready with pend != 0: load the next selection in the same cycle (back-to-back, no bubble) and stay in SHOW.
  - On valid&&ready with pend == 0: valid <= 0, go to EMPTY. out keeps its last value.
- Latency:
  - Edge sampled at cycle t, pend bit set at t+1, valid=1 with out at t+2 if EMPTY.
  - Sustained throughput: one event per cycle with ready held at 1.
- en=0: capture is blocked only. Existing pend and the handshake keep draining.
- Reset mid-operation: all state clears immediately. Pending events are lost. A line still high after reset counts as an edge on the first cycle after release, because in_d=0.
- busy = valid | (|pend), combinational from registers.

Decomposition:
- Package enc_evt_pkg:
  - WIDTH=8, IDX_W=3.
  - State encoding ST_EMPTY=1'b0, ST_SHOW=1'b1.
  - Function onehot(idx) returning the 8-bit one-hot of idx.
- Sub-module prio_sel8: purely combinational.
  - Inputs: mask[7:0], start[2:0], rr.
  - Outputs: idx[2:0], any.
  - rr=0 ignores start and returns the highest set bit.
  - Reused by any later arbiter in the codebase.
- Top level holds the edge detector, pend register, FSM, rr_ptr and drop register.

Test Plan:
- Reset then single edge: rst_n released, en=1, in 8'h00 -> 8'h10 held high, ready=0 -> valid=1 and out=3'd4 two cycles after the sampled edge. Hold in high -> no second event. busy=1 until the handshake completes.
- Fixed priority, simultaneous edges: RR_MODE=0, in 8'h00 -> 8'h25, ready=1 -> out sequence 5, 2, 0 on consecutive cycles. valid drops the cycle after the 0 is accepted. drop never asserts.
- Round-robin: RR_MODE=1, first grant index 5, then bits 7 and 1 pending -> next grants 7, then 1 (wrap).
- Drop/merge: bit 3 pending and not yet presented (valid busy with index 6, ready=0); toggle in[3] low then high -> drop=1 for one cycle. Index 3 is presented exactly once after 6 is accepted.
- Enable gating: en=0 while in 8'h00 -> 8'hFF -> no capture, valid stays 0, busy=0. Then en=1 with in still high -> no event, since no new edge.
- Set-wins and reset mid-op: bit 2's edge arrives the same cycle bit 2 is loaded into out -> bit 2 remains pending and is presented again next. Then assert rst_n=0 mid-SHOW -> out=0, valid=0, busy=0 immediately (asynchronously).
